fib_hist: RTL and testbench

Parametrised Fibonacci engine. It computes F(n) modulo 2^WIDTH iteratively, one term per clock, and keeps a circular history of the last HIST_DEPTH terms preceding F(n). It then accumulates a windowed sum of that history sequentially and presents the results over a valid/ready output handshake with a sticky overflow flag. Any history entry can be read back through a registered random-access port.

---
 rtl/fib_hist.sv | 153 +++++++++++++++
 tb/tb_fib_hist.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fib_hist.sv
// Iterative Fibonacci engine with a circular history of the terms that
// precede F(n), a sequential windowed sum over that history, a valid/ready
// result handshake and a registered random-access history read port.
module fib_hist #(
    parameter int WIDTH      = 32,
    parameter int N_WIDTH    = 16,
    parameter int HIST_DEPTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_stb,
    input  logic [N_WIDTH-1:0]            i_n,
    output logic                          o_busy,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [WIDTH-1:0]              o_fib,
    output logic [WIDTH-1:0]              o_sum,
    output logic [$clog2(HIST_DEPTH):0]   o_count,
    output logic                          o_ovf,
    input  logic [$clog2(HIST_DEPTH)-1:0] i_hist_idx,
    output logic [WIDTH-1:0]              o_hist_data
);

    localparam int PTR_W = $clog2(HIST_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(HIST_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(HIST_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_SUM,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [N_WIDTH-1:0] r_iter;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   r_sum_idx;
    logic [WIDTH-1:0]   r_hist [HIST_DEPTH];

    logic [WIDTH:0]     w_ab;
    logic [PTR_W-1:0]   w_sum_ptr;
    logic [PTR_W-1:0]   w_rd_ptr;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_last_iter;

    // Next term with its carry-out; the carry flags overflow of F(n+1).
    assign w_ab        = {1'b0, r_a} + {1'b0, r_b};
    assign w_last_iter = (r_iter == N_WIDTH'(1));
    // Newest entry sits just behind the write pointer; index k walks backwards.
    assign w_sum_ptr   = r_wr_ptr - PTR_W'(1) - r_sum_idx;
    assign w_rd_ptr    = r_wr_ptr - PTR_W'(1) - i_hist_idx;
    assign w_addend    = ({1'b0, r_sum_idx} < r_count) ? r_hist[w_sum_ptr] : '0;
    assign w_acc_next  = r_acc + w_addend;

    // State register with synchronous reset taking priority in every state.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    // Next-state selection: n == 0 skips straight to the summing phase.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_stb) w_next = (i_n != '0) ? S_RUN : S_SUM;
            S_RUN:  if (w_last_iter) w_next = S_SUM;
            S_SUM:  if (r_sum_idx == LAST_IDX) w_next = S_DONE;
            S_DONE: if (i_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Busy indication derived purely from the current state.
    always_comb begin
        o_busy = (r_state != S_IDLE);
    end

    // Iteration, history bookkeeping, summation and result registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_iter    <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_sum_idx <= '0;
            o_valid   <= 1'b0;
            o_fib     <= '0;
            o_sum     <= '0;
            o_count   <= '0;
            o_ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_stb) begin
                        r_iter    <= i_n;
                        r_a       <= '0;
                        r_b       <= WIDTH'(1);
                        r_acc     <= '0;
                        r_count   <= '0;
                        r_sum_idx <= '0;
                        o_ovf     <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    if (r_count != FULL_CNT) r_count <= r_count + CNT_W'(1);
                    r_a    <= r_b;
                    r_b    <= w_ab[WIDTH-1:0];
                    r_iter <= r_iter - N_WIDTH'(1);
                    if (w_ab[WIDTH] && !w_last_iter) o_ovf <= 1'b1;
                end
                S_SUM: begin
                    r_acc     <= w_acc_next;
                    r_sum_idx <= r_sum_idx + PTR_W'(1);
                    if (r_sum_idx == LAST_IDX) begin
                        o_valid <= 1'b1;
                        o_fib   <= r_a;
                        o_sum   <= w_acc_next;
                        o_count <= r_count;
                    end
                end
                S_DONE: begin
                    if (i_ready) o_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // History storage: each RUN edge pushes the current term; no reset needed.
    always_ff @(posedge i_clk) begin
        if (i_reset_n && r_state == S_RUN) r_hist[r_wr_ptr] <= r_a;
    end

    // Registered history read; entries beyond the valid count read as zero.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n)                         o_hist_data <= '0;
        else if ({1'b0, i_hist_idx} < r_count)  o_hist_data <= r_hist[w_rd_ptr];
        else                                    o_hist_data <= '0;
    end

endmodule

// File: tb/tb_fib_hist.sv
// Directed testbench for fib_hist: a 32-bit instance exercises latency,
// history readback, stalls and reset; an 8-bit instance exercises overflow
// and back-to-back requests.
module tb_fib_hist;

    logic clk = 1'b0;
    logic rstN;

    logic        stb32, ready32, busy32, valid32, ovf32;
    logic [15:0] n32;
    logic [31:0] fib32, sum32, histData32;
    logic [3:0]  count32;
    logic [2:0]  idx32;

    logic        stb8, ready8, busy8, valid8, ovf8;
    logic [15:0] n8;
    logic [7:0]  fib8, sum8, histData8;
    logic [3:0]  count8;
    logic [2:0]  idx8;

    int compCount = 0;
    int failCount = 0;

    fib_hist #(.WIDTH(32), .N_WIDTH(16), .HIST_DEPTH(8)) dut32 (
        .i_clk(clk), .i_reset_n(rstN), .i_stb(stb32), .i_n(n32),
        .o_busy(busy32), .o_valid(valid32), .i_ready(ready32),
        .o_fib(fib32), .o_sum(sum32), .o_count(count32), .o_ovf(ovf32),
        .i_hist_idx(idx32), .o_hist_data(histData32)
    );

    fib_hist #(.WIDTH(8), .N_WIDTH(16), .HIST_DEPTH(8)) dut8 (
        .i_clk(clk), .i_reset_n(rstN), .i_stb(stb8), .i_n(n8),
        .o_busy(busy8), .o_valid(valid8), .i_ready(ready8),
        .o_fib(fib8), .o_sum(sum8), .o_count(count8), .o_ovf(ovf8),
        .i_hist_idx(idx8), .o_hist_data(histData8)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitValid32(input int expLat, input string tag);
        int edges = 0;
        while (!valid32 && edges < 300) begin
            tick();
            edges++;
        end
        checkOutput({tag, "_latency"}, 64'(edges), 64'(expLat));
    endtask

    // Pulse a request into the 32-bit instance and wait for its result.
    task automatic applyStimulus(input int n, input string tag);
        stb32 = 1'b1;
        n32   = 16'(n);
        tick();
        stb32 = 1'b0;
        checkOutput({tag, "_busy"}, 64'(busy32), 64'd1);
        waitValid32(n + 8, tag);
    endtask

    // One idle edge so a completed result returns the DUT to IDLE.
    task automatic releaseResult32(input string tag);
        tick();
        checkOutput({tag, "_valid_drop"}, 64'(valid32), 64'd0);
    endtask

    task automatic applyStimulus8(input int n, input string tag);
        int edges = 0;
        stb8 = 1'b1;
        n8   = 16'(n);
        tick();
        stb8 = 1'b0;
        while (!valid8 && edges < 300) begin
            tick();
            edges++;
        end
        checkOutput({tag, "_latency"}, 64'(edges), 64'(n + 8));
    endtask

    task automatic readHist32(input int idx, input int exp, input string tag);
        idx32 = 3'(idx);
        tick();
        checkOutput($sformatf("%s_hist%0d", tag, idx), 64'(histData32), 64'(exp));
    endtask

    int hist10 [8] = '{34, 21, 13, 8, 5, 3, 2, 1};
    int hist3  [8] = '{1, 1, 0, 0, 0, 0, 0, 0};

    initial begin
        rstN = 1'b0;
        stb32 = 1'b0; n32 = '0; ready32 = 1'b1; idx32 = '0;
        stb8  = 1'b0; n8  = '0; ready8  = 1'b1; idx8  = '0;
        tick();
        tick();
        checkOutput("rst_busy", 64'(busy32), 64'd0);
        checkOutput("rst_valid", 64'(valid32), 64'd0);
        checkOutput("rst_fib", 64'(fib32), 64'd0);
        checkOutput("rst_count", 64'(count32), 64'd0);
        checkOutput("rst_hist", 64'(histData32), 64'd0);
        checkOutput("rst_busy8", 64'(busy8), 64'd0);
        rstN = 1'b1;
        tick();

        // n = 10: full history window
        applyStimulus(10, "n10");
        checkOutput("n10_fib", 64'(fib32), 64'd55);
        checkOutput("n10_sum", 64'(sum32), 64'd87);
        checkOutput("n10_count", 64'(count32), 64'd8);
        checkOutput("n10_ovf", 64'(ovf32), 64'd0);
        releaseResult32("n10");
        for (int i = 0; i < 8; i++) readHist32(i, hist10[i], "n10");

        // n = 0: empty history
        applyStimulus(0, "n0");
        checkOutput("n0_fib", 64'(fib32), 64'd0);
        checkOutput("n0_sum", 64'(sum32), 64'd0);
        checkOutput("n0_count", 64'(count32), 64'd0);
        checkOutput("n0_ovf", 64'(ovf32), 64'd0);
        releaseResult32("n0");
        for (int i = 0; i < 8; i++) readHist32(i, 0, "n0");

        // n = 3: partial history
        applyStimulus(3, "n3");
        checkOutput("n3_fib", 64'(fib32), 64'd2);
        checkOutput("n3_sum", 64'(sum32), 64'd2);
        checkOutput("n3_count", 64'(count32), 64'd3);
        releaseResult32("n3");
        for (int i = 0; i < 8; i++) readHist32(i, hist3[i], "n3");

        // 8-bit overflow boundary and back-to-back requests
        applyStimulus8(13, "w8n13");
        checkOutput("w8n13_fib", 64'(fib8), 64'd233);
        checkOutput("w8n13_ovf", 64'(ovf8), 64'd0);
        tick();
        applyStimulus8(14, "w8n14");
        checkOutput("w8n14_fib", 64'(fib8), 64'd121);
        checkOutput("w8n14_ovf", 64'(ovf8), 64'd1);
        tick();
        applyStimulus8(1, "w8n1");
        checkOutput("w8n1_fib", 64'(fib8), 64'd1);
        checkOutput("w8n1_sum", 64'(sum8), 64'd0);
        checkOutput("w8n1_count", 64'(count8), 64'd1);
        checkOutput("w8n1_ovf", 64'(ovf8), 64'd0);
        tick();
        applyStimulus8(2, "w8n2");
        checkOutput("w8n2_fib", 64'(fib8), 64'd1);
        checkOutput("w8n2_sum", 64'(sum8), 64'd1);
        checkOutput("w8n2_count", 64'(count8), 64'd2);
        checkOutput("w8n2_ovf", 64'(ovf8), 64'd0);
        tick();

        // Stalled consumer with a strobe during the stall
        ready32 = 1'b0;
        applyStimulus(4, "stall");
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                stb32 = 1'b1;
                n32   = 16'd9;
            end
            tick();
            stb32 = 1'b0;
            checkOutput($sformatf("stall%0d_valid", c), 64'(valid32), 64'd1);
            checkOutput($sformatf("stall%0d_fib", c), 64'(fib32), 64'd3);
            checkOutput($sformatf("stall%0d_sum", c), 64'(sum32), 64'd4);
            checkOutput($sformatf("stall%0d_count", c), 64'(count32), 64'd4);
            checkOutput($sformatf("stall%0d_busy", c), 64'(busy32), 64'd1);
        end
        ready32 = 1'b1;
        stb32   = 1'b1;
        n32     = 16'd7;
        tick();
        checkOutput("release_valid", 64'(valid32), 64'd0);
        checkOutput("release_busy", 64'(busy32), 64'd0);
        tick();
        stb32 = 1'b0;
        checkOutput("reaccept_busy", 64'(busy32), 64'd1);
        waitValid32(15, "n7");
        checkOutput("n7_fib", 64'(fib32), 64'd13);
        checkOutput("n7_sum", 64'(sum32), 64'd20);
        checkOutput("n7_count", 64'(count32), 64'd7);
        releaseResult32("n7");

        // Reset in the middle of RUN
        stb32 = 1'b1;
        n32   = 16'd20;
        tick();
        stb32 = 1'b0;
        repeat (5) tick();
        checkOutput("midrun_busy", 64'(busy32), 64'd1);
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        checkOutput("midrst_busy", 64'(busy32), 64'd0);
        checkOutput("midrst_valid", 64'(valid32), 64'd0);
        checkOutput("midrst_fib", 64'(fib32), 64'd0);
        checkOutput("midrst_sum", 64'(sum32), 64'd0);
        checkOutput("midrst_count", 64'(count32), 64'd0);
        checkOutput("midrst_hist", 64'(histData32), 64'd0);
        checkOutput("midrst_fib8", 64'(fib8), 64'd0);
        applyStimulus(5, "n5");
        checkOutput("n5_fib", 64'(fib32), 64'd5);
        checkOutput("n5_sum", 64'(sum32), 64'd7);
        checkOutput("n5_count", 64'(count32), 64'd5);
        releaseResult32("n5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule
